branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Parametrised successor to the ID-stage branch resolver.
- IF side: predicts direction and target from a direct-mapped BTB and a table of 2-bit saturating counters.
- ID side: resolves the branch using forwarded operands, detects load-use hazards, flags mispredicts with a redirect PC, and trains the tables on the clock edge.
- Sits between the PC-select mux (IF) and the IF/ID pipeline register.

Parameters:
- DATA_W, 32, datapath and PC width.
- IDX_W, 6, index bits; table depth = 2^IDX_W entries.
- TAG_W, 8, BTB tag bits, taken from pc[IDX_W+TAG_W+1 : IDX_W+2].

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_pc  in  DATA_W  fetch PC.
- pred_taken  out  1  IF prediction: taken.
- pred_target  out  DATA_W  IF predicted target.
- id_valid  in  1  ID-stage instruction valid.
- id_pc  in  DATA_W  PC of ID instruction.
- id_ins  in  32  ID instruction word.
- id_pred_taken  in  1  prediction carried with the ID instruction.
- id_pred_target  in  DATA_W  predicted target carried with the ID instruction.
- reg_rs_data, reg_rt_data  in  DATA_W  register file reads.
- id_ex_regd, ex_mem_regd, mem_wb_regd  in  5  destination registers.
- id_ex_wr, ex_mem_wr, mem_wb_wr  in  1  destination write enables.
- id_ex_memread, ex_mem_memread  in  1  stage holds a load.
- id_ex_data, ex_mem_data, mem_wb_data  in  DATA_W  forwardable results.
- stall  out  1  hold PC and IF/ID for one cycle.
- mispredict  out  1  flush IF/ID and redirect.
- redirect_pc  out  DATA_W  correct next PC.

Behaviour:
- Reset (async, any time, including mid-update):
  - all counters = 2'b01; all BTB valid bits = 0.
  - Outputs go combinational-0: pred_taken=0, pred_target=0, stall=0, mispredict=0, redirect_pc=0.
  - No write completes while reset is high.
- IF lookup (combinational from registered tables):
  - idx = if_pc[IDX_W+1:2].
  - hit = valid[idx] and tag[idx] equals if_pc tag field.
  - pred_taken = hit & ctr[idx][1].
  - pred_target = hit ? btb_target[idx] : if_pc+4.
- Branch decode (opcode id_ins[31:26]):
  - 000100 beq: rs==rt.
  - 000101 bne: rs!=rt.
  - 000110 blez: signed rs<=0.
  - 000111 bgtz: signed rs>0.
  - 000001 regimm: rt field 00001 bgez (signed rs>=0); rt field 00000 bltz (signed rs<0).
  - Any other opcode or rt field: not a branch.
  - All comparisons are signed, DATA_W-bit.
- Forwarding per source (rs = id_ins[25:21], rt = id_ins[20:16]):
  - Priority ID/EX, then EX/MEM, then MEM/WB, then register file.
  - A stage matches only if its wr=1 and regd==src and src!=0.
  - Register 0 always reads 0.
  - rt is used only by beq/bne.
- Load-use stall:
  - Condition: id_valid and branch and a used source matches an enabled ID/EX or EX/MEM stage whose memread=1.
  - Effect: stall=1, mispredict=0, no table update; re-evaluated next cycle.
  - An ID/EX load stalls 2 cycles; an EX/MEM load stalls 1 cycle.
- Resolution (id_valid, branch, no stall):
  - target = id_pc + 4 + (sign_extend(id_ins[15:0]) << 2), modulo 2^DATA_W (wraps).
  - mispredict = (taken != id_pred_taken) | (taken & id_pred_taken & target != id_pred_target).
  - redirect_pc = taken ? target : id_pc+4.
  - Non-branch instruction with id_pred_taken=1: mispredict=1, redirect_pc=id_pc+4, and the BTB entry is invalidated at the edge.
- Training at the rising clk edge, on resolution:
  - Counter saturating: taken increments to at most 3; not-taken decrements to at least 0.
  - If taken: BTB entry written with valid=1, tag, target.
  - A new BTB allocation (previous valid=0 or tag differed) also writes the counter to 2'b10 instead of incrementing.
- Same-cycle collision: an IF lookup at the index being trained returns the pre-update value (no bypass).
- id_valid=0: no stall, no mispredict, no update.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds three outputs, each a 32-bit counter:
  - stat_branches: resolved branches.
  - stat_mispredicts: mispredicts.
  - stat_stalls: stall cycles.
- Counters reset to 0, increment at the clk edge, and wrap from 0xFFFFFFFF to 0.
- When not defined, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset then if_pc=0x100 -> pred_taken=0, pred_target=0x104. Then beq r1,r2 at id_pc=0x100 with offset 4, r1=r2=5, id_pred_taken=0 -> mispredict=1, redirect_pc=0x114. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x114.
- Same beq resolved not-taken four times -> counter 2->1->0->0 (saturates). Lookup gives pred_taken=0 from the first not-taken onward.
- bne rs=r3 with ID/EX writing r3=7 and MEM/WB writing r3=9, rt=r0 -> forwarded value 7 used, branch taken. Same case with id_ex_wr=0 -> 9 used.
- ID/EX load to r4, bgtz r4 -> stall=1 for 2 cycles, no mispredict, counters unchanged, then resolves with ex_mem_data... after mem_wb forwarding. Load-use test with regd=0 -> no stall.
- id_pc=0xFFFFFFFC, offset 0 -> target 0x00000000 (wrap). bltz with rs=0x80000000 -> taken. bgez with rs=0 -> taken.
- Assert reset during a taken resolution -> BTB valid=0 and counters=1 immediately; lookup at that PC then gives pred_taken=0. With BRANCH_STATS_EN, all stats read 0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch predictor and ID-stage resolver: direct-mapped BTB plus 2-bit counters for IF,
// forwarding/load-use/mispredict logic for ID. Optional counters under BRANCH_STATS_EN.
module branch_predict_unit #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [DATA_W-1:0] pred_target,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [31:0]       id_ins,
  input  logic              id_pred_taken,
  input  logic [DATA_W-1:0] id_pred_target,
  input  logic [DATA_W-1:0] reg_rs_data,
  input  logic [DATA_W-1:0] reg_rt_data,
  input  logic [4:0]        id_ex_regd,
  input  logic [4:0]        ex_mem_regd,
  input  logic [4:0]        mem_wb_regd,
  input  logic              id_ex_wr,
  input  logic              ex_mem_wr,
  input  logic              mem_wb_wr,
  input  logic              id_ex_memread,
  input  logic              ex_mem_memread,
  input  logic [DATA_W-1:0] id_ex_data,
  input  logic [DATA_W-1:0] ex_mem_data,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic              stall,
  output logic              mispredict,
  output logic [DATA_W-1:0] redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts,
  output logic [31:0]       stat_stalls
`endif
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]        ctr_q   [DEPTH];
  logic [TAG_W-1:0]  tag_q   [DEPTH];
  logic [DATA_W-1:0] tgt_q   [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  // IF lookup reads the registered tables only, so a same-cycle update is not bypassed.
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx      = if_pc[IDX_W+1:2];
  assign if_tag      = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = !reset && if_hit && ctr_q[if_idx][1];
  assign pred_target = reset ? '0 : (if_hit ? tgt_q[if_idx] : if_pc + DATA_W'(4));

  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       is_branch, use_rt, taken;

  assign opcode = id_ins[31:26];
  assign rs     = id_ins[25:21];
  assign rt     = id_ins[20:16];

  // Forwarded operands: nearest producing stage wins, r0 is hard-wired to zero.
  logic [DATA_W-1:0] rs_val, rt_val;

  assign rs_val = (rs == 5'd0)                      ? '0 :
                  (id_ex_wr  && id_ex_regd  == rs)  ? id_ex_data :
                  (ex_mem_wr && ex_mem_regd == rs)  ? ex_mem_data :
                  (mem_wb_wr && mem_wb_regd == rs)  ? mem_wb_data : reg_rs_data;
  assign rt_val = (rt == 5'd0)                      ? '0 :
                  (id_ex_wr  && id_ex_regd  == rt)  ? id_ex_data :
                  (ex_mem_wr && ex_mem_regd == rt)  ? ex_mem_data :
                  (mem_wb_wr && mem_wb_regd == rt)  ? mem_wb_data : reg_rt_data;

  logic rs_neg, rs_zero;
  assign rs_neg  = rs_val[DATA_W-1];
  assign rs_zero = (rs_val == '0);

  always_comb begin
    is_branch = 1'b0;
    use_rt    = 1'b0;
    taken     = 1'b0;
    unique case (opcode)
      6'b000100: begin is_branch = 1'b1; use_rt = 1'b1; taken = (rs_val == rt_val); end
      6'b000101: begin is_branch = 1'b1; use_rt = 1'b1; taken = (rs_val != rt_val); end
      6'b000110: begin is_branch = 1'b1; taken = rs_neg || rs_zero; end
      6'b000111: begin is_branch = 1'b1; taken = !rs_neg && !rs_zero; end
      6'b000001: begin
        if (rt == 5'b00001) begin is_branch = 1'b1; taken = !rs_neg; end
        else if (rt == 5'b00000) begin is_branch = 1'b1; taken = rs_neg; end
      end
      default: ;
    endcase
  end

  logic rs_load, rt_load, stall_int;

  assign rs_load = (rs != 5'd0) &&
                   ((id_ex_wr  && id_ex_memread  && id_ex_regd  == rs) ||
                    (ex_mem_wr && ex_mem_memread && ex_mem_regd == rs));
  assign rt_load = (rt != 5'd0) &&
                   ((id_ex_wr  && id_ex_memread  && id_ex_regd  == rt) ||
                    (ex_mem_wr && ex_mem_memread && ex_mem_regd == rt));
  assign stall_int = id_valid && is_branch && (rs_load || (use_rt && rt_load));

  logic [DATA_W-1:0] pc4, sext, br_target;
  logic              resolve, bogus, mis_int;

  assign pc4       = id_pc + DATA_W'(4);
  assign sext      = {{(DATA_W-16){id_ins[15]}}, id_ins[15:0]};
  assign br_target = pc4 + {sext[DATA_W-3:0], 2'b00};
  assign resolve   = id_valid && is_branch && !stall_int;
  // A non-branch that IF believed taken: undo the fetch and drop its BTB entry.
  assign bogus     = id_valid && !is_branch && id_pred_taken;
  assign mis_int   = (resolve && ((taken != id_pred_taken) ||
                                  (taken && id_pred_taken && br_target != id_pred_target)))
                     || bogus;

  assign stall       = !reset && stall_int;
  assign mispredict  = !reset && mis_int;
  assign redirect_pc = reset   ? '0 :
                       resolve ? (taken ? br_target : pc4) :
                       bogus   ? pc4 : '0;

  logic [IDX_W-1:0] id_idx;
  logic [TAG_W-1:0] id_tag;
  logic             alloc;

  assign id_idx = id_pc[IDX_W+1:2];
  assign id_tag = id_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign alloc  = !valid_q[id_idx] || (tag_q[id_idx] != id_tag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= 2'b01;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (resolve) begin
      if (taken) begin
        valid_q[id_idx] <= 1'b1;
        tag_q[id_idx]   <= id_tag;
        tgt_q[id_idx]   <= br_target;
        if (alloc) ctr_q[id_idx] <= 2'b10;
        else if (ctr_q[id_idx] != 2'b11) ctr_q[id_idx] <= ctr_q[id_idx] + 2'b01;
      end else if (ctr_q[id_idx] != 2'b00) begin
        ctr_q[id_idx] <= ctr_q[id_idx] - 2'b01;
      end
    end else if (bogus) begin
      valid_q[id_idx] <= 1'b0;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
      stat_stalls      <= '0;
    end else begin
      if (resolve)   stat_branches    <= stat_branches + 32'd1;
      if (mis_int)   stat_mispredicts <= stat_mispredicts + 32'd1;
      if (stall_int) stat_stalls      <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule
